// File: rtl/present_out_pkg.sv
// Shared widths and state encodings for the PRESENT result collector.
// Holds the block/word/byte sizes and both FSM encodings.
package present_out_pkg;

  localparam int BLOCK_W         = 64;
  localparam int WORD_W          = 32;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_BLOCK = 8;
  localparam int IDX_W           = $clog2(BYTES_PER_BLOCK);

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } cap_state_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/present_out_collector_if.sv
// Signal bundle between the PRESENT core / byte sink and the collector.
// Byte stream: a byte transfers on a rising clk edge when byte_valid and byte_ready are both high;
// once byte_valid rises, byte_data/byte_last hold and byte_valid stays high until that transfer.
interface present_out_collector_if
  import present_out_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);

  logic [WORD_W-1:0] din;
  logic              done1;
  logic              done2;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_last;
  logic              byte_ready;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic              seq_err;
  cap_state_t        cap_state;
  ser_state_t        ser_state;

  modport master (
    output din, done1, done2, byte_ready,
    input  byte_data, byte_valid, byte_last, fifo_count, overflow, seq_err,
           cap_state, ser_state
  );

  modport slave (
    input  din, done1, done2, byte_ready,
    output byte_data, byte_valid, byte_last, fifo_count, overflow, seq_err,
           cap_state, ser_state
  );

endinterface

// File: rtl/present_out_collector_block_fifo.sv
// Circular FIFO of 64-bit blocks with exact occupancy count.
// A write while full is accepted only when a read happens in the same cycle.
module block_fifo
  import present_out_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [BLOCK_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [BLOCK_W-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [BLOCK_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_wr;
  logic               do_rd;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && (!full || rd_en);
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/present_out_collector.sv
// Reassembles PRESENT hi/lo result words into 64-bit blocks, queues them,
// and streams each block MSB-first as bytes over a valid/ready port.
module present_out_collector
  import present_out_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input logic                  clk,
  input logic                  rst,
  present_out_collector_if.slave bus
);

  logic               done1_q;
  logic               done2_q;
  logic               d1_rise;
  logic               d2_rise;
  cap_state_t         cap_state;
  cap_state_t         cap_next;
  logic [WORD_W-1:0]  hi_reg;
  logic               hi_load;
  logic               push;
  logic               set_seq;
  logic               seq_err_q;
  logic               overflow_q;

  logic [BLOCK_W-1:0] fifo_rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_cnt;

  ser_state_t         ser_state;
  ser_state_t         ser_next;
  logic [BLOCK_W-1:0] shift_reg;
  logic [IDX_W-1:0]   byte_idx;
  logic               pop;
  logic               hs;
  logic               last_byte;

  assign d1_rise = bus.done1 & ~done1_q;
  assign d2_rise = bus.done2 & ~done2_q;

  // Capture FSM: simultaneous edges are an ordering error and discard both words.
  always_comb begin
    cap_next = cap_state;
    hi_load  = 1'b0;
    push     = 1'b0;
    set_seq  = 1'b0;
    if (d1_rise && d2_rise) begin
      cap_next = WAIT_HI;
      set_seq  = 1'b1;
    end else begin
      unique case (cap_state)
        WAIT_HI: begin
          if (d1_rise) begin
            hi_load  = 1'b1;
            cap_next = WAIT_LO;
          end else if (d2_rise) begin
            set_seq = 1'b1;
          end
        end
        WAIT_LO: begin
          if (d2_rise) begin
            push     = 1'b1;
            cap_next = WAIT_HI;
          end else if (d1_rise) begin
            hi_load = 1'b1;
            set_seq = 1'b1;
          end
        end
        default: cap_next = WAIT_HI;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done1_q    <= 1'b0;
      done2_q    <= 1'b0;
      cap_state  <= WAIT_HI;
      hi_reg     <= '0;
      seq_err_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done1_q   <= bus.done1;
      done2_q   <= bus.done2;
      cap_state <= cap_next;
      if (hi_load) hi_reg <= bus.din;
      if (set_seq) seq_err_q <= 1'b1;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  block_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({hi_reg, bus.din}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign hs        = (ser_state == S_SEND) && bus.byte_ready;
  assign last_byte = (byte_idx == IDX_W'(BYTES_PER_BLOCK - 1));

  // Serializer: a block is only loaded from S_IDLE, so each block costs one idle cycle.
  always_comb begin
    ser_next = ser_state;
    pop      = 1'b0;
    unique case (ser_state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          ser_next = S_SEND;
        end
      end
      S_SEND: begin
        if (hs && last_byte) ser_next = S_IDLE;
      end
      default: ser_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ser_state <= S_IDLE;
      shift_reg <= '0;
      byte_idx  <= '0;
    end else begin
      ser_state <= ser_next;
      if (pop) begin
        shift_reg <= fifo_rd_data;
        byte_idx  <= '0;
      end else if (hs) begin
        shift_reg <= shift_reg << BYTE_W;
        byte_idx  <= byte_idx + 1'b1;
      end
    end
  end

  // shift_reg is zero whenever idle, so byte_data reads 0 outside S_SEND.
  assign bus.byte_valid = (ser_state == S_SEND);
  assign bus.byte_data  = shift_reg[BLOCK_W-1 -: BYTE_W];
  assign bus.byte_last  = (ser_state == S_SEND) && last_byte;
  assign bus.fifo_count = fifo_cnt;
  assign bus.overflow   = overflow_q;
  assign bus.seq_err    = seq_err_q;
  assign bus.cap_state  = cap_state;
  assign bus.ser_state  = ser_state;

endmodule

// File: tb/tb_present_out_collector.sv
// Directed bench for present_out_collector: hand-computed blocks go into an
// expected byte queue that a negedge monitor drains on every handshake.
module tb_present_out_collector;
  import present_out_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  present_out_collector_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  present_out_collector #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks   = 0;
  int         errors   = 0;
  int         hs_count = 0;
  logic [8:0] exp_q[$];
  bit         stall_q  = 1'b0;
  logic [8:0] stall_val;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] byte_of(input logic [63:0] blk, input int i);
    logic [7:0] b;
    b = blk[63-8*i -: 8];
    return {(i == 7), b};
  endfunction

  task automatic add_block(input logic [63:0] blk);
    for (int i = 0; i < 8; i++) exp_q.push_back(byte_of(blk, i));
  endtask

  // One-cycle pulse on done1 (hi=1) or done2 (hi=0); returns 1ns after the sampling edge.
  task automatic pulse(input bit hi, input logic [31:0] w);
    @(posedge clk); #1;
    bus.din = w;
    if (hi) bus.done1 = 1'b1;
    else    bus.done2 = 1'b1;
    @(posedge clk); #1;
    bus.done1 = 1'b0;
    bus.done2 = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] blk);
    pulse(1'b1, blk[63:32]);
    pulse(1'b0, blk[31:0]);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every observed handshake must match the head of exp_q; stalled bytes must hold.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_q = 1'b0;
      end else if (bus.byte_valid) begin
        if (stall_q) chk("hold_byte", {55'd0, bus.byte_last, bus.byte_data}, {55'd0, stall_val});
        if (bus.byte_ready) begin
          chk("byte_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0)
            chk("stream_byte", {55'd0, bus.byte_last, bus.byte_data}, {55'd0, exp_q.pop_front()});
          hs_count++;
          stall_q = 1'b0;
        end else begin
          stall_q   = 1'b1;
          stall_val = {bus.byte_last, bus.byte_data};
        end
      end else begin
        if (stall_q) chk("valid_held", 64'(bus.byte_valid), 64'd1);
        stall_q = 1'b0;
      end
    end
  end

  initial begin
    logic [63:0] blk;
    logic [0:3]  pat;
    int          hs_start;

    bus.din        = '0;
    bus.done1      = 1'b0;
    bus.done2      = 1'b0;
    bus.byte_ready = 1'b0;
    pat            = 4'b1001;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", 64'(bus.byte_valid), 64'd0);
    chk("rst_data", 64'(bus.byte_data), 64'd0);
    chk("rst_last", 64'(bus.byte_last), 64'd0);
    chk("rst_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_seq_err", 64'(bus.seq_err), 64'd0);
    chk("rst_cap_state", 64'(bus.cap_state), 64'(WAIT_HI));
    chk("rst_ser_state", 64'(bus.ser_state), 64'(S_IDLE));

    // Single block, sink always ready: latency and consecutive bytes
    bus.byte_ready = 1'b1;
    blk = 64'h0123_4567_89AB_CDEF;
    add_block(blk);
    send_block(blk);
    chk("lat_count_n", 64'(bus.fifo_count), 64'd1);
    chk("lat_valid_n", 64'(bus.byte_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_valid_n1", 64'(bus.byte_valid), 64'd1);
    chk("lat_count_n1", 64'(bus.fifo_count), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_valid", 64'(bus.byte_valid), 64'd1);
      chk("t1_byte", {55'd0, bus.byte_last, bus.byte_data}, {55'd0, byte_of(blk, i)});
    end
    @(negedge clk);
    chk("t1_idle_gap", 64'(bus.byte_valid), 64'd0);
    drain("t1_drain", 20);

    // Backpressure with ready pattern 1,0,0,1
    bus.byte_ready = 1'b0;
    blk = 64'hDEAD_BEEF_CAFE_F00D;
    add_block(blk);
    send_block(blk);
    for (int c = 0; c < 400; c++) begin
      if (exp_q.size() == 0) break;
      bus.byte_ready = pat[c % 4];
      @(posedge clk); #1;
    end
    bus.byte_ready = 1'b1;
    drain("bp_drain", 20);

    // Long done1 pulse: only the first-cycle word counts
    @(posedge clk); #1;
    bus.din   = 32'hC0DE_0001;
    bus.done1 = 1'b1;
    @(posedge clk); #1;
    bus.din   = 32'hC0DE_0002;
    @(posedge clk); #1;
    bus.din   = 32'hC0DE_0003;
    @(posedge clk); #1;
    bus.done1 = 1'b0;
    add_block(64'hC0DE_0001_5555_6666);
    pulse(1'b0, 32'h5555_6666);
    drain("long_drain", 40);
    chk("long_seq_err", 64'(bus.seq_err), 64'd0);

    // Sequence errors
    pulse(1'b0, 32'h9999_9999);
    @(posedge clk); #1;
    chk("lone_d2_seq_err", 64'(bus.seq_err), 64'd1);
    chk("lone_d2_count", 64'(bus.fifo_count), 64'd0);
    chk("lone_d2_state", 64'(bus.cap_state), 64'(WAIT_HI));
    pulse(1'b1, 32'hAAAA_0000);
    pulse(1'b1, 32'hBBBB_0000);
    add_block(64'hBBBB_0000_1111_2222);
    pulse(1'b0, 32'h1111_2222);
    drain("dbl_d1_drain", 40);

    pulse(1'b1, 32'h1212_1212);
    chk("both_pre_state", 64'(bus.cap_state), 64'(WAIT_LO));
    @(posedge clk); #1;
    bus.din   = 32'h3434_3434;
    bus.done1 = 1'b1;
    bus.done2 = 1'b1;
    @(posedge clk); #1;
    bus.done1 = 1'b0;
    bus.done2 = 1'b0;
    chk("both_state", 64'(bus.cap_state), 64'(WAIT_HI));
    chk("both_count", 64'(bus.fifo_count), 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("both_no_stream", 64'(bus.byte_valid), 64'd0);

    // Overflow: block 1 sits in the serializer, blocks 2-5 fill the FIFO, block 6 is dropped
    bus.byte_ready = 1'b0;
    chk("ovf_pre_flag", 64'(bus.overflow), 64'd0);
    for (int k = 1; k <= 6; k++) begin
      blk = {32'h1000_0000 + 32'(k), 32'hF000_0000 + 32'(k)};
      if (k <= 5) add_block(blk);
      send_block(blk);
      if (k == 5) begin
        chk("ovf_count5", 64'(bus.fifo_count), 64'd4);
        chk("ovf_flag5", 64'(bus.overflow), 64'd0);
      end
    end
    chk("ovf_count6", 64'(bus.fifo_count), 64'd4);
    chk("ovf_flag6", 64'(bus.overflow), 64'd1);
    bus.byte_ready = 1'b1;
    drain("ovf_drain", 200);
    repeat (20) @(posedge clk); #1;
    chk("ovf_no_block6", 64'(bus.byte_valid), 64'd0);
    chk("ovf_count_end", 64'(bus.fifo_count), 64'd0);

    // Reset mid-stream after byte 3 of block 1 with block 2 queued
    bus.byte_ready = 1'b0;
    blk = 64'h1122_3344_5566_7788;
    add_block(blk);
    send_block(blk);
    send_block(64'h99AA_BBCC_DDEE_FF00);
    chk("mid_pre_count", 64'(bus.fifo_count), 64'd1);
    hs_start = hs_count;
    bus.byte_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (hs_count >= hs_start + 4) break;
    end
    bus.byte_ready = 1'b0;
    chk("mid_bytes_sent", 64'(hs_count - hs_start), 64'd4);
    chk("mid_pre_valid", 64'(bus.byte_valid), 64'd1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 64'(bus.byte_valid), 64'd0);
    chk("mid_rst_data", 64'(bus.byte_data), 64'd0);
    chk("mid_rst_last", 64'(bus.byte_last), 64'd0);
    chk("mid_rst_count", 64'(bus.fifo_count), 64'd0);
    chk("mid_rst_overflow", 64'(bus.overflow), 64'd0);
    chk("mid_rst_seq_err", 64'(bus.seq_err), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.byte_ready = 1'b1;
    blk = 64'h0F1E_2D3C_4B5A_6978;
    add_block(blk);
    send_block(blk);
    drain("post_rst_drain", 40);
    repeat (5) @(posedge clk); #1;
    chk("post_rst_idle", 64'(bus.byte_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
